// File: rtl/frame_delimiter_inserter.sv
// frame_delimiter_inserter
//   Brackets every vsync-delimited frame of a payload byte stream with an SOF
//   pattern (on vsync rise) and an EOF pattern (on the accepted vsync fall).
//   A tagged FIFO of {sof, eof, dv, data} entries absorbs input while the
//   patterns are being emitted. The output side uses a registered valid/ready
//   handshake.
//   Optional build macro FRAME_LEN_EN: counts payload words per frame and
//   appends the count (LEN_BYTES words, MS word first) after the EOF pattern.
// Ports
//   clock      system clock
//   nreset     asynchronous active-low reset
//   in_valid   in_data valid this cycle (no upstream backpressure)
//   in_data    payload word
//   vsync      frame-active level, synchronous to clock
//   out_valid  out_data valid (registered)
//   out_data   output word (registered)
//   out_ready  downstream accepts the word when out_valid && out_ready
//   in_frame   high between an accepted vsync rise and the matching fall
//   overflow   sticky, a payload word was lost to a full FIFO
module frame_delimiter_inserter #(
    parameter int unsigned  DATA_WIDTH  = 8,
    parameter int unsigned  FIFO_DEPTH  = 16,
    parameter int unsigned  SOF_BYTES   = 2,
    parameter logic [127:0] SOF_PATTERN = 128'hffd8,
    parameter int unsigned  EOF_BYTES   = 2,
    parameter logic [127:0] EOF_PATTERN = 128'hffd9,
    parameter int unsigned  LEN_BYTES   = 4
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  vsync,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  in_frame,
    output logic                  overflow
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LEN_W = 8 * LEN_BYTES;
`ifdef FRAME_LEN_EN
    localparam int unsigned ENT_W = DATA_WIDTH + 3 + LEN_W;
`else
    localparam int unsigned ENT_W = DATA_WIDTH + 3;
`endif
    localparam logic       SOF_EN   = (SOF_BYTES != 32'd0);
    localparam logic [7:0] SOF_CNT  = 8'(SOF_BYTES);
    localparam logic [7:0] SOF_LAST = SOF_CNT - 8'd1;
    localparam logic [7:0] EOF_CNT  = 8'(EOF_BYTES);
    localparam logic [7:0] EOF_LAST = EOF_CNT - 8'd1;

`ifdef FRAME_LEN_EN
    localparam logic [7:0] LEN_CNT  = 8'(LEN_BYTES);
    localparam logic [7:0] LEN_LAST = LEN_CNT - 8'd1;
    typedef enum logic [1:0] {S_PASS = 2'd0, S_SOF = 2'd1, S_EOF = 2'd2, S_LEN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_PASS = 2'd0, S_SOF = 2'd1, S_EOF = 2'd2} state_t;
`endif

    // Word idx of an nwords-long pattern, MS word first.
    function automatic logic [DATA_WIDTH-1:0] pick_word(input logic [127:0] pat,
                                                        input logic [7:0]   nwords,
                                                        input logic [7:0]   idx);
        logic [127:0] sh;
        sh = pat >> (DATA_WIDTH * 32'(nwords - idx - 8'd1));
        return sh[DATA_WIDTH-1:0];
    endfunction

    logic                  vsync_prev_r, armed_r, in_frame_r, overflow_r;
    logic                  pend_sof_r, pend_eof_r;
    logic [AW:0]           wr_ptr_r, rd_ptr_r;
    logic [ENT_W-1:0]      mem_r [FIFO_DEPTH];
    logic                  rise_s, fall_acc_s, wr_req_s, wr_ok_s, full_s, empty_s, pop_s;
    logic [ENT_W-1:0]      wr_entry_s, rd_entry_s;
    logic                  e_sof_s, e_eof_s, e_dv_s;
    logic [DATA_WIDTH-1:0] e_data_s;

    state_t                state_r, state_s;
    logic [7:0]            idx_r, idx_s;
    logic                  cur_dv_r, cur_dv_s, cur_eof_r, cur_eof_s, last_s;
    logic [DATA_WIDTH-1:0] cur_data_r, cur_data_s;
    logic                  out_valid_r, out_valid_s;
    logic [DATA_WIDTH-1:0] out_data_r, out_data_s;

    // The detector is armed one cycle after reset so a vsync level that is
    // already high at release is not mistaken for a rise.
    assign rise_s     = vsync & ~vsync_prev_r & armed_r;
    assign fall_acc_s = ~vsync & vsync_prev_r & in_frame_r;
    assign wr_req_s   = rise_s | fall_acc_s | in_valid | pend_sof_r | pend_eof_r;
    assign full_s     = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign wr_ok_s    = wr_req_s & ~full_s;

`ifdef FRAME_LEN_EN
    logic [LEN_W-1:0] frame_cnt_r, frame_cnt_s, pend_len_r, cur_len_r, cur_len_s, e_len_s;

    // Payload counter: restarts on rise, counts every dv word of the frame
    // (lost ones included), saturates at all-ones.
    always_comb begin
        frame_cnt_s = frame_cnt_r;
        if (rise_s) begin
            frame_cnt_s = {{(LEN_W-1){1'b0}}, in_valid};
        end else if (in_frame_r && in_valid && (frame_cnt_r != {LEN_W{1'b1}})) begin
            frame_cnt_s = frame_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            frame_cnt_s = frame_cnt_r;
        end
    end

    // Counter and the length held back while an eof waits for FIFO space.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            frame_cnt_r <= {LEN_W{1'b0}};
            pend_len_r  <= {LEN_W{1'b0}};
        end else begin
            frame_cnt_r <= frame_cnt_s;
            if (fall_acc_s && full_s) begin
                pend_len_r <= frame_cnt_s;
            end
        end
    end

    assign wr_entry_s = {(fall_acc_s ? frame_cnt_s : pend_len_r), rise_s | pend_sof_r,
                         fall_acc_s | pend_eof_r, in_valid, in_data};
    assign e_len_s    = rd_entry_s[ENT_W-1 -: LEN_W];
`else
    assign wr_entry_s = {rise_s | pend_sof_r, fall_acc_s | pend_eof_r, in_valid, in_data};
`endif

    assign rd_entry_s = mem_r[rd_ptr_r[AW-1:0]];
    assign e_data_s   = rd_entry_s[DATA_WIDTH-1:0];
    assign e_dv_s     = rd_entry_s[DATA_WIDTH];
    assign e_eof_s    = rd_entry_s[DATA_WIDTH+1];
    assign e_sof_s    = rd_entry_s[DATA_WIDTH+2];

    // FIFO storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_entry_s;
        end
    end

    // Edge detection, frame flag, sticky overflow, pending markers, pointers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            vsync_prev_r <= 1'b0;
            armed_r      <= 1'b0;
            in_frame_r   <= 1'b0;
            overflow_r   <= 1'b0;
            pend_sof_r   <= 1'b0;
            pend_eof_r   <= 1'b0;
            wr_ptr_r     <= {(AW+1){1'b0}};
            rd_ptr_r     <= {(AW+1){1'b0}};
        end else begin
            vsync_prev_r <= vsync;
            armed_r      <= 1'b1;
            if (rise_s) begin
                in_frame_r <= 1'b1;
            end else if (fall_acc_s) begin
                in_frame_r <= 1'b0;
            end
            if (wr_req_s && full_s && in_valid) begin
                overflow_r <= 1'b1;
            end
            // Markers that hit a full FIFO ride along with the next write.
            if (wr_req_s && full_s) begin
                pend_sof_r <= pend_sof_r | rise_s;
                pend_eof_r <= pend_eof_r | fall_acc_s;
            end else if (wr_ok_s) begin
                pend_sof_r <= 1'b0;
                pend_eof_r <= 1'b0;
            end
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Emission FSM: next state, next output word and FIFO pop.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        cur_dv_s    = cur_dv_r;
        cur_eof_s   = cur_eof_r;
        cur_data_s  = cur_data_r;
`ifdef FRAME_LEN_EN
        cur_len_s   = cur_len_r;
`endif
        out_valid_s = out_valid_r & ~out_ready;
        out_data_s  = out_data_r;
        pop_s       = 1'b0;
        last_s      = 1'b0;
        if (out_valid_r && !out_ready) begin
            // Stalled: hold the presented word and the FSM.
            out_valid_s = 1'b1;
        end else begin
            case (state_r)
                S_PASS: begin
                    if (!empty_s) begin
                        pop_s      = 1'b1;
                        cur_dv_s   = e_dv_s;
                        cur_eof_s  = e_eof_s;
                        cur_data_s = e_data_s;
`ifdef FRAME_LEN_EN
                        cur_len_s  = e_len_s;
`endif
                        idx_s      = 8'd0;
                        if (e_sof_s && SOF_EN) begin
                            state_s = S_SOF;
                        end else if (e_dv_s) begin
                            out_valid_s = 1'b1;
                            out_data_s  = e_data_s;
                            state_s     = e_eof_s ? S_EOF : S_PASS;
                        end else if (e_eof_s) begin
                            state_s = S_EOF;
                        end else begin
                            state_s = S_PASS;
                        end
                    end else begin
                        state_s = S_PASS;
                    end
                end
                S_SOF: begin
                    out_valid_s = 1'b1;
                    // Index SOF_CNT presents the entry's own data word.
                    if (idx_r < SOF_CNT) begin
                        out_data_s = pick_word(SOF_PATTERN, SOF_CNT, idx_r);
                        last_s     = (idx_r == SOF_LAST) && !cur_dv_r;
                    end else begin
                        out_data_s = cur_data_r;
                        last_s     = 1'b1;
                    end
                    if (last_s) begin
                        idx_s   = 8'd0;
                        state_s = cur_eof_r ? S_EOF : S_PASS;
                    end else begin
                        idx_s = idx_r + 8'd1;
                    end
                end
                S_EOF: begin
                    out_valid_s = 1'b1;
                    out_data_s  = pick_word(EOF_PATTERN, EOF_CNT, idx_r);
                    if (idx_r == EOF_LAST) begin
                        idx_s = 8'd0;
`ifdef FRAME_LEN_EN
                        state_s = S_LEN;
`else
                        state_s = S_PASS;
`endif
                    end else begin
                        idx_s = idx_r + 8'd1;
                    end
                end
`ifdef FRAME_LEN_EN
                S_LEN: begin
                    out_valid_s = 1'b1;
                    out_data_s  = pick_word({{(128-LEN_W){1'b0}}, cur_len_r}, LEN_CNT, idx_r);
                    if (idx_r == LEN_LAST) begin
                        idx_s   = 8'd0;
                        state_s = S_PASS;
                    end else begin
                        idx_s = idx_r + 8'd1;
                    end
                end
`endif
                default: begin
                    idx_s   = 8'd0;
                    state_s = S_PASS;
                end
            endcase
        end
    end

    // FSM state, current entry and the registered output word.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r     <= S_PASS;
            idx_r       <= 8'd0;
            cur_dv_r    <= 1'b0;
            cur_eof_r   <= 1'b0;
            cur_data_r  <= {DATA_WIDTH{1'b0}};
`ifdef FRAME_LEN_EN
            cur_len_r   <= {LEN_W{1'b0}};
`endif
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            cur_dv_r    <= cur_dv_s;
            cur_eof_r   <= cur_eof_s;
            cur_data_r  <= cur_data_s;
`ifdef FRAME_LEN_EN
            cur_len_r   <= cur_len_s;
`endif
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign in_frame  = in_frame_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_frame_delimiter_inserter.sv
// Directed-vector bench for frame_delimiter_inserter (default parameters).
module tb_frame_delimiter_inserter;

    logic       clock     = 1'b0;
    logic       nreset    = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       vsync     = 1'b0;
    logic       rdy       = 1'b1;
    logic       toggle_en = 1'b0;
    logic       tog       = 1'b0;
    logic       out_ready_s;
    logic       out_valid;
    logic [7:0] out_data;
    logic       in_frame;
    logic       overflow;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         stall_viol = 0;
    int         stall_seen = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    frame_delimiter_inserter dut (
        .clock     (clock),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .vsync     (vsync),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready_s),
        .in_frame  (in_frame),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) tog <= ~tog;
    assign out_ready_s = toggle_en ? tog : rdy;

    // Collect every word that transfers at the coming rising edge.
    always @(negedge clock) begin
        if (nreset && out_valid && out_ready_s) got_q.push_back(out_data);
    end

    // A stalled word must stay valid and unchanged until accepted.
    always @(negedge clock) begin
        if (stall_prev && nreset && ((out_valid !== 1'b1) || (out_data !== stall_data)))
            stall_viol = stall_viol + 1;
        stall_prev = nreset && out_valid && !out_ready_s;
        if (stall_prev) stall_seen = stall_seen + 1;
        stall_data = out_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic put(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Compare collected words with exp_q, then clear both.
    task automatic check_seq(input string tag);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic frame3(input string tag);
        vsync = 1'b1;
        tick();
        chk({tag, "_in_frame_set"}, 32'(in_frame), 32'd1);
        put(8'h11);
        put(8'h22);
        put(8'h33);
        vsync = 1'b0;
        tick();
        chk({tag, "_in_frame_clr"}, 32'(in_frame), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in_frame",  32'(in_frame),  32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        nreset = 1'b1;
        idle(2);

        // Latency: word at cycle n shows at n+2, unframed word passes alone
        in_valid = 1'b1;
        in_data  = 8'h5a;
        tick();
        in_valid = 1'b0;
        chk("lat_n1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_n2_valid", 32'(out_valid), 32'd1);
        chk("lat_n2_data",  32'(out_data),  32'h5a);
        idle(3);
        exp_q = '{8'h5a};
        check_seq("lat_seq");

        // Basic frame, out_ready held high
        frame3("f2");
        idle(20);
        exp_q = '{8'hff, 8'hd8, 8'h11, 8'h22, 8'h33, 8'hff, 8'hd9};
        check_seq("f2_seq");

        // Same frame with out_ready toggling every cycle
        toggle_en = 1'b1;
        frame3("f3");
        idle(40);
        toggle_en = 1'b0;
        rdy = 1'b1;
        idle(2);
        exp_q = '{8'hff, 8'hd8, 8'h11, 8'h22, 8'h33, 8'hff, 8'hd9};
        check_seq("f3_seq");
        chk("f3_stall_seen",   32'(stall_seen > 0), 32'd1);
        chk("f3_stall_stable", 32'(stall_viol),     32'd0);

        // Overflow: 20 words into a 16-deep FIFO with the sink blocked
        rdy   = 1'b0;
        vsync = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) put(8'h40 + 8'(i));
        chk("ovf_before_fall", 32'(overflow), 32'd1);
        vsync = 1'b0;
        tick();
        chk("ovf_in_frame_clr", 32'(in_frame), 32'd0);
        idle(3);
        rdy = 1'b1;
        idle(50);
        exp_q = '{8'hff, 8'hd8};
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h40 + 8'(i));
        exp_q.push_back(8'hff);
        exp_q.push_back(8'hd9);
        check_seq("ovf_seq");
        chk("ovf_sticky",       32'(overflow),   32'd1);
        chk("ovf_stall_stable", 32'(stall_viol), 32'd0);

        // Reset mid-frame with the FIFO partly full
        rdy   = 1'b0;
        vsync = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) put(8'h80 + 8'(i));
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        #2;
        nreset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data",  32'(out_data),  32'd0);
        chk("mid_rst_in_frame",  32'(in_frame),  32'd0);
        chk("mid_rst_overflow",  32'(overflow),  32'd0);
        vsync = 1'b0;
        idle(2);
        nreset = 1'b1;
        got_q.delete();
        rdy = 1'b1;
        idle(15);
        chk("mid_no_stale", 32'(got_q.size()), 32'd0);

        // vsync already high at reset release: its fall is ignored
        nreset = 1'b0;
        vsync  = 1'b1;
        tick();
        nreset = 1'b1;
        idle(3);
        chk("vh_in_frame_high", 32'(in_frame), 32'd0);
        vsync = 1'b0;
        idle(3);
        chk("vh_in_frame_low", 32'(in_frame), 32'd0);
        idle(5);
        chk("vh_no_words", 32'(got_q.size()), 32'd0);
        vsync = 1'b1;
        tick();
        put(8'haa);
        vsync = 1'b0;
        tick();
        idle(15);
        exp_q = '{8'hff, 8'hd8, 8'haa, 8'hff, 8'hd9};
        check_seq("vh_next_frame");

        // Rise and fall on consecutive cycles: SOF straight into EOF
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        idle(15);
        exp_q = '{8'hff, 8'hd8, 8'hff, 8'hd9};
        check_seq("empty_frame");

`ifdef FRAME_LEN_EN
        // 300-word frame: count 0x0000012c follows the EOF pattern
        vsync = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) put(8'(i));
        vsync = 1'b0;
        tick();
        idle(30);
        chk("len_total", 32'(got_q.size()), 32'd308);
        if (got_q.size() == 308) begin
            chk("len_sof0", 32'(got_q[0]),   32'hff);
            chk("len_sof1", 32'(got_q[1]),   32'hd8);
            chk("len_pay0", 32'(got_q[2]),   32'h00);
            chk("len_eof0", 32'(got_q[302]), 32'hff);
            chk("len_eof1", 32'(got_q[303]), 32'hd9);
            chk("len_b3",   32'(got_q[304]), 32'h00);
            chk("len_b2",   32'(got_q[305]), 32'h00);
            chk("len_b1",   32'(got_q[306]), 32'h01);
            chk("len_b0",   32'(got_q[307]), 32'h2c);
        end
        got_q.delete();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
